// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment display driver.
// A prescaler produces a slot tick every REFRESH_DIV clocks. Each tick
// advances the scanned digit. New display data is double-buffered: a load
// goes into a pending buffer, which is copied to the active buffer only when
// the scan wraps back to digit 0, so a frame never shows mixed data.
// seg, an and frame_start are registered from the next-cycle scan state.
// This means the outputs change on the same edge as the digit index.
// hex_mode and digit_en act as live inputs with one clock of latency.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros
// on digits 1..NUM_DIGITS-1. Digit 0 is never blanked.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    hex_mode,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         prescaler_r;
    logic [IW-1:0]         index_r;
    logic [DW-1:0]         active_digits_r;
    logic [NUM_DIGITS-1:0] active_dp_r;
    logic [DW-1:0]         pend_digits_r;
    logic [NUM_DIGITS-1:0] pend_dp_r;
    logic                  pend_valid_r;

    logic                  tick_s;
    logic                  wrap_s;
    logic [PW-1:0]         prescaler_next_s;
    logic [IW-1:0]         idx_next_s;
    logic [DW-1:0]         active_digits_next_s;
    logic [NUM_DIGITS-1:0] active_dp_next_s;
    logic [3:0]            code_s;
    logic                  dp_bit_s;
    logic                  en_bit_s;
    logic [7:0]            glyph_s;
    logic [7:0]            seg_s;
    logic [NUM_DIGITS-1:0] an_s;

    // Glyphs are active-low a..g in bits 7..1. Bit 0 (dp) is returned as off.
    function automatic logic [7:0] glyph(input logic [3:0] code, input logic hex_en);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'h03;
            4'h1:    g = 8'h9F;
            4'h2:    g = 8'h25;
            4'h3:    g = 8'h0D;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h49;
            4'h6:    g = 8'h41;
            4'h7:    g = 8'h1F;
            4'h8:    g = 8'h01;
            4'h9:    g = 8'h09;
            4'hA:    g = hex_en ? 8'h11 : 8'hFF;
            4'hB:    g = hex_en ? 8'hC1 : 8'hFF;
            4'hC:    g = hex_en ? 8'h63 : 8'hFF;
            4'hD:    g = hex_en ? 8'h85 : 8'hFF;
            4'hE:    g = hex_en ? 8'h61 : 8'hFF;
            4'hF:    g = hex_en ? 8'h71 : 8'hFF;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit above position 0 is a leading zero when it and every higher digit is zero.
    function automatic logic lz_blank(input logic [DW-1:0] codes, input logic [IW-1:0] idx);
        logic [DW-1:0] upper;
        upper = codes >> {idx, 2'b00};
        return (idx != {IW{1'b0}}) && (upper == {DW{1'b0}});
    endfunction
`endif

    // Scan sequencing: prescaler tick, digit index advance and frame wrap.
    always_comb begin
        tick_s = (prescaler_r == PRE_LAST);
        wrap_s = tick_s && (index_r == IDX_LAST);
        if (tick_s) begin
            prescaler_next_s = {PW{1'b0}};
        end else begin
            prescaler_next_s = prescaler_r + PW'(1);
        end
        if (wrap_s) begin
            idx_next_s = {IW{1'b0}};
        end else if (tick_s) begin
            idx_next_s = index_r + IW'(1);
        end else begin
            idx_next_s = index_r;
        end
    end

    // Active buffer update: a load on the wrap tick goes straight to active,
    // otherwise pending data is committed at the wrap.
    always_comb begin
        if (wrap_s && load) begin
            active_digits_next_s = digits;
            active_dp_next_s     = dp_in;
        end else if (wrap_s && pend_valid_r) begin
            active_digits_next_s = pend_digits_r;
            active_dp_next_s     = pend_dp_r;
        end else begin
            active_digits_next_s = active_digits_r;
            active_dp_next_s     = active_dp_r;
        end
    end

    // Segment and anode pattern for the digit that is shown after the next edge.
    always_comb begin
        code_s   = 4'(active_digits_next_s >> {idx_next_s, 2'b00});
        dp_bit_s = 1'(active_dp_next_s >> idx_next_s);
        en_bit_s = 1'(digit_en >> idx_next_s);
        glyph_s  = glyph(code_s, hex_mode);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (lz_blank(active_digits_next_s, idx_next_s)) begin
            glyph_s = 8'hFF;
        end else begin
            glyph_s = glyph_s;
        end
`endif
        seg_s = {glyph_s[7:1], ~dp_bit_s};
        if (en_bit_s) begin
            an_s = ~(NUM_DIGITS'(1'b1) << idx_next_s);
        end else begin
            an_s = {NUM_DIGITS{1'b1}};
        end
    end

    // Prescaler and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r <= {PW{1'b0}};
            index_r     <= {IW{1'b0}};
        end else begin
            prescaler_r <= prescaler_next_s;
            index_r     <= idx_next_s;
        end
    end

    // Double buffer. A repeated load overwrites pending; a wrap empties pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_digits_r <= {DW{1'b0}};
            active_dp_r     <= {NUM_DIGITS{1'b0}};
            pend_digits_r   <= {DW{1'b0}};
            pend_dp_r       <= {NUM_DIGITS{1'b0}};
            pend_valid_r    <= 1'b0;
        end else begin
            active_digits_r <= active_digits_next_s;
            active_dp_r     <= active_dp_next_s;
            if (load && !wrap_s) begin
                pend_digits_r <= digits;
                pend_dp_r     <= dp_in;
                pend_valid_r  <= 1'b1;
            end else if (wrap_s) begin
                pend_valid_r  <= 1'b0;
            end else begin
                pend_valid_r  <= pend_valid_r;
            end
        end
    end

    // Registered display outputs. frame_start marks the first cycle of digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= 8'hFF;
            an          <= {NUM_DIGITS{1'b1}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_s;
            an          <= an_s;
            frame_start <= wrap_s;
        end
    end

endmodule
